// File: rtl/fft_pingpong_ram_if.sv
// Bus bundle for the FFT ping-pong RAM: fill-side port A,
// compute-side port B, plus the bank-swap handshake.
interface fft_pingpong_ram_if #(
  parameter int DW = 32,
  parameter int AW = 10
);
  logic          a_en;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_din;
  logic [DW-1:0] a_dout;
  logic          a_rvalid;
  logic          a_done;
  logic          b_en;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_din;
  logic [DW-1:0] b_dout;
  logic          b_rvalid;
  logic          b_done;
  logic          bank_sel;
  logic          swap;
  logic          a_pend;
  logic          b_pend;
  logic          done_err;

  modport master (
    output a_en, a_we, a_addr, a_din, a_done,
    output b_en, b_we, b_addr, b_din, b_done,
    input  a_dout, a_rvalid, b_dout, b_rvalid,
    input  bank_sel, swap, a_pend, b_pend, done_err
  );

  modport slave (
    input  a_en, a_we, a_addr, a_din, a_done,
    input  b_en, b_we, b_addr, b_din, b_done,
    output a_dout, a_rvalid, b_dout, b_rvalid,
    output bank_sel, swap, a_pend, b_pend, done_err
  );
endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank ping-pong RAM: port A fills one bank while port B
// works in place on the other; banks swap on a done/done handshake.
module fft_pingpong_ram #(
  parameter int DW       = 32,
  parameter int DEPTH    = 1024,
  parameter int AW       = $clog2(DEPTH),
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_pingpong_ram_if.slave    bus
);
  typedef enum logic [1:0] {
    IDLE,
    WAIT_A,
    WAIT_B,
    SWAP
  } state_t;

  state_t state, state_n;
  logic   bank_sel;
  logic   swap_q;
  logic   err_q;
  logic   toggle;
  logic   err_set;

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];

  logic          a_wr, b_wr;
  logic [DW-1:0] a_old, b_old;
  logic [DW-1:0] a_rd, b_rd;
  logic [DW-1:0] a_q1, b_q1;
  logic          a_v1, b_v1;

  assign a_wr = bus.a_en & bus.a_we;
  assign b_wr = bus.b_en & bus.b_we;

  // Each bank is owned by exactly one port at a time.
  always_ff @(posedge clk) begin
    if (a_wr && !bank_sel) mem0[bus.a_addr] <= bus.a_din;
    if (b_wr && bank_sel)  mem0[bus.b_addr] <= bus.b_din;
  end

  always_ff @(posedge clk) begin
    if (a_wr && bank_sel)  mem1[bus.a_addr] <= bus.a_din;
    if (b_wr && !bank_sel) mem1[bus.b_addr] <= bus.b_din;
  end

  always_comb begin
    a_old = bank_sel ? mem1[bus.a_addr] : mem0[bus.a_addr];
    b_old = bank_sel ? mem0[bus.b_addr] : mem1[bus.b_addr];
    a_rd  = a_old;
    b_rd  = b_old;
    if (RDW_MODE != 0 && a_wr) a_rd = bus.a_din;
    if (RDW_MODE != 0 && b_wr) b_rd = bus.b_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q1 <= '0;
      a_v1 <= 1'b0;
      b_q1 <= '0;
      b_v1 <= 1'b0;
    end else begin
      a_v1 <= bus.a_en;
      b_v1 <= bus.b_en;
      if (bus.a_en) a_q1 <= a_rd;
      if (bus.b_en) b_q1 <= b_rd;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DW-1:0] a_q2, b_q2;
    logic          a_v2, b_v2;

    always_ff @(posedge clk) begin
      if (rst) begin
        a_q2 <= '0;
        a_v2 <= 1'b0;
        b_q2 <= '0;
        b_v2 <= 1'b0;
      end else begin
        a_v2 <= a_v1;
        b_v2 <= b_v1;
        if (a_v1) a_q2 <= a_q1;
        if (b_v1) b_q2 <= b_q1;
      end
    end

    assign bus.a_dout   = a_q2;
    assign bus.a_rvalid = a_v2;
    assign bus.b_dout   = b_q2;
    assign bus.b_rvalid = b_v2;
  end else begin : g_lat1
    assign bus.a_dout   = a_q1;
    assign bus.a_rvalid = a_v1;
    assign bus.b_dout   = b_q1;
    assign bus.b_rvalid = b_v1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bank_sel <= 1'b0;
      swap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      bank_sel <= bank_sel ^ toggle;
      swap_q   <= toggle;
      err_q    <= err_q | err_set;
    end
  end

  // In SWAP a fresh done belongs to the next frame, not an error.
  always_comb begin
    state_n = state;
    toggle  = 1'b0;
    err_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.a_done && bus.b_done) state_n = SWAP;
        else if (bus.a_done)          state_n = WAIT_B;
        else if (bus.b_done)          state_n = WAIT_A;
      end
      WAIT_A: begin
        if (bus.a_done) state_n = SWAP;
        if (bus.b_done) err_set = 1'b1;
      end
      WAIT_B: begin
        if (bus.b_done) state_n = SWAP;
        if (bus.a_done) err_set = 1'b1;
      end
      SWAP: begin
        toggle = 1'b1;
        if (bus.a_done && bus.b_done) state_n = SWAP;
        else if (bus.a_done)          state_n = WAIT_B;
        else if (bus.b_done)          state_n = WAIT_A;
        else                          state_n = IDLE;
      end
    endcase
  end

  assign bus.bank_sel = bank_sel;
  assign bus.swap     = swap_q;
  assign bus.done_err = err_q;
  assign bus.a_pend   = (state == WAIT_B) || (state == SWAP);
  assign bus.b_pend   = (state == WAIT_A) || (state == SWAP);
endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Directed bench: u1 (latency 1, read-first) for access and handshake,
// u2/u3 (latency 2, read-first / write-first) on identical stimulus.
module tb_fft_pingpong_ram;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errs   = 0;

  always #5 clk = ~clk;

  fft_pingpong_ram_if #(.DW(32), .AW(4)) p1 ();
  fft_pingpong_ram_if #(.DW(32), .AW(4)) p2 ();
  fft_pingpong_ram_if #(.DW(32), .AW(4)) p3 ();

  fft_pingpong_ram #(.DW(32), .DEPTH(16), .RD_LAT(1), .RDW_MODE(0))
    u1 (.clk(clk), .rst(rst), .bus(p1));
  fft_pingpong_ram #(.DW(32), .DEPTH(16), .RD_LAT(2), .RDW_MODE(0))
    u2 (.clk(clk), .rst(rst), .bus(p2));
  fft_pingpong_ram #(.DW(32), .DEPTH(16), .RD_LAT(2), .RDW_MODE(1))
    u3 (.clk(clk), .rst(rst), .bus(p3));

  assign p3.a_en   = p2.a_en;
  assign p3.a_we   = p2.a_we;
  assign p3.a_addr = p2.a_addr;
  assign p3.a_din  = p2.a_din;
  assign p3.a_done = p2.a_done;
  assign p3.b_en   = p2.b_en;
  assign p3.b_we   = p2.b_we;
  assign p3.b_addr = p2.b_addr;
  assign p3.b_din  = p2.b_din;
  assign p3.b_done = p2.b_done;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    p1.a_en = 0; p1.a_we = 0; p1.a_addr = '0; p1.a_din = '0;
    p1.b_en = 0; p1.b_we = 0; p1.b_addr = '0; p1.b_din = '0;
    p1.a_done = 0; p1.b_done = 0;
    p2.a_en = 0; p2.a_we = 0; p2.a_addr = '0; p2.a_din = '0;
    p2.b_en = 0; p2.b_we = 0; p2.b_addr = '0; p2.b_din = '0;
    p2.a_done = 0; p2.b_done = 0;

    tick;
    tick;
    rst = 1'b0;
    chk("rst_bank_sel", p1.bank_sel, 0);
    chk("rst_swap", p1.swap, 0);
    chk("rst_pend", {p1.a_pend, p1.b_pend}, 0);
    chk("rst_err", p1.done_err, 0);
    chk("rst_a_dout", p1.a_dout, 0);
    chk("rst_b_dout", p1.b_dout, 0);
    chk("rst_l2_dout", p2.a_dout, 0);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("idle_rvalid", {p1.a_rvalid, p1.b_rvalid,
                          p2.a_rvalid, p3.b_rvalid}, 0);
    end

    // A writes bank0, B writes bank1, same address
    p1.a_en = 1; p1.a_we = 1; p1.a_addr = 4'd5; p1.a_din = 32'hDEAD0001;
    p1.b_en = 1; p1.b_we = 1; p1.b_addr = 4'd5; p1.b_din = 32'hB0B00005;
    tick;
    chk("wr_a_rvalid", p1.a_rvalid, 1);
    p1.a_we = 0; p1.b_we = 0;
    tick;
    chk("rd_a_dout", p1.a_dout, 32'hDEAD0001);
    chk("rd_a_rvalid", p1.a_rvalid, 1);
    chk("rd_b_dout", p1.b_dout, 32'hB0B00005);
    p1.a_en = 0; p1.b_en = 0;
    tick;
    chk("hold_rvalid", p1.a_rvalid, 0);
    chk("hold_dout", p1.a_dout, 32'hDEAD0001);

    // Ping-pong swap
    p1.a_done = 1;
    tick;
    p1.a_done = 0;
    chk("pp_a_pend", {p1.a_pend, p1.b_pend}, 2'b10);
    tick; tick; tick;
    chk("pp_wait", {p1.a_pend, p1.swap, p1.bank_sel}, 3'b100);
    p1.b_done = 1;
    tick;
    p1.b_done = 0;
    chk("pp_both", {p1.a_pend, p1.b_pend, p1.swap, p1.bank_sel}, 4'b1100);
    tick;
    chk("pp_swap", {p1.a_pend, p1.b_pend, p1.swap, p1.bank_sel}, 4'b0011);
    tick;
    chk("pp_swap_pulse", p1.swap, 0);
    p1.a_en = 1; p1.b_en = 1;
    tick;
    p1.a_en = 0; p1.b_en = 0;
    chk("pp_b_dout", p1.b_dout, 32'hDEAD0001);
    chk("pp_a_dout", p1.a_dout, 32'hB0B00005);

    // Simultaneous done
    p1.a_done = 1; p1.b_done = 1;
    tick;
    p1.a_done = 0; p1.b_done = 0;
    chk("sim_pend", {p1.a_pend, p1.b_pend, p1.swap}, 3'b110);
    tick;
    chk("sim_swap", {p1.a_pend, p1.b_pend, p1.swap, p1.bank_sel}, 4'b0010);

    // Double done on A
    p1.a_done = 1;
    tick;
    p1.a_done = 0;
    chk("err_first", {p1.a_pend, p1.done_err}, 2'b10);
    p1.a_done = 1;
    tick;
    p1.a_done = 0;
    chk("err_set", {p1.a_pend, p1.done_err, p1.swap}, 3'b110);
    p1.b_done = 1;
    tick;
    p1.b_done = 0;
    chk("err_b_pend", p1.b_pend, 1);
    p1.a_done = 1;
    tick;
    p1.a_done = 0;
    chk("swap_edge_done",
        {p1.a_pend, p1.b_pend, p1.swap, p1.bank_sel, p1.done_err},
        5'b10111);

    // Latency 2, read-during-write
    p2.a_en = 1; p2.a_we = 1; p2.a_addr = 4'd7; p2.a_din = 32'h11;
    tick;
    p2.a_en = 0; p2.a_we = 0;
    tick;
    chk("l2_rvalid_on", p2.a_rvalid, 1);
    tick;
    chk("l2_rvalid_off", p2.a_rvalid, 0);
    p2.a_en = 1; p2.a_we = 1; p2.a_din = 32'h22;
    tick;
    p2.a_en = 0; p2.a_we = 0;
    chk("l2_not_yet", {p2.a_rvalid, p3.a_rvalid}, 0);
    tick;
    chk("rdw_old", p2.a_dout, 32'h11);
    chk("rdw_new", p3.a_dout, 32'h22);
    chk("rdw_rvalid", {p2.a_rvalid, p3.a_rvalid}, 2'b11);
    tick;
    chk("rdw_done", {p2.a_rvalid, p3.a_rvalid}, 0);
    chk("rdw_hold", p2.a_dout, 32'h11);

    // Reset with a read in flight
    p2.a_en = 1;
    tick;
    p2.a_en = 0;
    rst = 1'b1;
    tick;
    chk("mid_rst_rvalid", {p2.a_rvalid, p3.a_rvalid}, 0);
    chk("mid_rst_dout", p2.a_dout, 0);
    chk("mid_rst_u1", {p1.bank_sel, p1.done_err, p1.a_pend}, 0);
    rst = 1'b0;
    tick;
    chk("post_rst_rvalid", {p2.a_rvalid, p3.a_rvalid}, 0);
    p2.a_en = 1;
    tick;
    p2.a_en = 0;
    tick;
    chk("post_rst_l2", p2.a_dout, 32'h22);
    chk("post_rst_l2w", p3.a_dout, 32'h22);
    chk("post_rst_valid", {p2.a_rvalid, p3.a_rvalid}, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule

// File: doc/fft_pingpong_ram.md
Name: fft_pingpong_ram

Overview:
- Parametrised two-bank (ping-pong) dual-port RAM for the FFT datapath.
- Port A is the load/unload side and always addresses the "fill" bank. Port B is the butterfly engine side and always performs in-place read/write on the "compute" bank.
- Banks swap through a done/done handshake, so loading frame n+1 overlaps computing frame n.
- Adds configurable read latency, read-during-write mode, read-valid tracking and handshake error detection.

Parameters:
- DW, 32, data word width in bits (complex re/im packed).
- DEPTH, 1024, words per bank; power of two, >= 4.
- AW, $clog2(DEPTH), address width (derived; do not override).
- RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).
- RDW_MODE, 0, same-port read-during-write to the same address: 0 = read-first (old data), 1 = write-first (new data).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- a_en  in  1  port A access enable.
- a_we  in  1  port A write enable (qualified by a_en).
- a_addr  in  AW  port A word address within the fill bank.
- a_din  in  DW  port A write data.
- a_dout  out  DW  port A read data.
- a_rvalid  out  1  a_dout holds data for an access issued RD_LAT cycles earlier.
- a_done  in  1  one-cycle pulse: fill bank fully loaded/unloaded.
- b_en, b_we, b_addr, b_din, b_dout, b_rvalid, b_done  same widths/meaning for port B on the compute bank.
- bank_sel  out  1  0: A→bank0, B→bank1; 1: A→bank1, B→bank0.
- swap  out  1  one-cycle pulse on the cycle bank_sel toggles.
- a_pend, b_pend  out  1  done flags latched, waiting for the partner.
- done_err  out  1  sticky: a done pulse arrived while that port's pend was already set.

Behaviour:
- Reset (rst high at posedge):
  - Clears bank_sel, a_pend, b_pend, swap, done_err, a_rvalid, b_rvalid, a_dout, b_dout and all read-pipeline stages to 0.
  - Memory contents are not cleared.
  - Reset mid-operation discards in-flight reads: no rvalid after reset.
- Bank mapping:
  - Sampled per access at the posedge where en is high, using the current bank_sel.
  - A and B always target different banks, so there are no cross-port collisions.
- Access:
  - en=1, we=1: writes din to [bank][addr] at that edge.
  - en=1 (any we): launches a read of [bank][addr].
  - RD_LAT=1: dout/rvalid update at the same edge.
  - RD_LAT=2: dout/rvalid update one edge later.
  - rvalid is 1 exactly RD_LAT cycles after each en=1 cycle, otherwise 0.
  - dout holds its last value while rvalid=0.
- Read-during-write on the same port and address follows RDW_MODE.
- Reads in flight across a swap return data from the bank they were issued against.
- Handshake state machine:
  - States: IDLE (neither pend), WAIT_A (b_pend only), WAIT_B (a_pend only), SWAP (both pend).
  - a_done sets a_pend; b_done sets b_pend; both in the same cycle set both.
  - From SWAP, the next edge toggles bank_sel, asserts swap for one cycle and clears both pends.
  - A done pulse arriving on the swap edge sets its pend for the next frame (set wins over clear).
  - A done while its own pend=1 sets done_err; pend stays 1 and no extra swap occurs.
- Accesses on the swap edge still use the old mapping; accesses on the next edge use the new one.
- Address is always within DEPTH (AW bits), so no wrap logic is required. Out-of-range handling is not applicable.
- Implementation: two inferred simple dual-port/true-dual-port arrays, one per bank. Muxing must not add latency beyond RD_LAT.

Test Plan:
- Reset then idle: all outputs 0; bank_sel=0; 10 idle cycles produce no rvalid.
- RD_LAT=1:
  - A writes 0xDEAD0001 at addr 5 (bank0).
  - Next cycle A reads addr 5 → a_dout=0xDEAD0001, a_rvalid=1 one edge later.
  - B reads addr 5 (bank1) → unwritten bank, no corruption from A.
- Ping-pong swap:
  - a_done at cycle 10, b_done at cycle 14 → a_pend=1 from 11, b_pend=1 from 15.
  - swap=1 and bank_sel=1 at edge 16; pends clear.
  - B then reads addr 5 → 0xDEAD0001.
- Simultaneous done and error:
  - a_done and b_done in the same cycle → swap exactly 2 edges later.
  - Second a_done while a_pend=1 → done_err=1, sticky until rst.
- RDW and latency:
  - RD_LAT=2, RDW_MODE=0: addr 7 holds 0x11; write 0x22 plus read addr 7 in the same cycle → dout=0x11 two edges later.
  - RDW_MODE=1: same stimulus returns 0x22.
- Reset mid-read: issue a read with RD_LAT=2, assert rst next cycle → rvalid stays 0. Memory still returns previously written data after reset.
